// File: rtl/iterative_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : iterative_alu                                                    |
// | Brief   : Handshaked XLEN-wide RV32I ALU with iterative RV32M mul/div,     |
// |           the latter compiled in only when ALU_MULDIV_EN is defined.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module iterative_alu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_operation,
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam int c_SHAMT_W = $clog2(XLEN);

    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_SUB  = 5'd1;
    localparam logic [4:0] c_OP_AND  = 5'd2;
    localparam logic [4:0] c_OP_OR   = 5'd3;
    localparam logic [4:0] c_OP_XOR  = 5'd4;
    localparam logic [4:0] c_OP_SLL  = 5'd5;
    localparam logic [4:0] c_OP_SRL  = 5'd6;
    localparam logic [4:0] c_OP_SRA  = 5'd7;
    localparam logic [4:0] c_OP_SLT  = 5'd8;
    localparam logic [4:0] c_OP_SLTU = 5'd9;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DONE = 2'd2;
`ifdef ALU_MULDIV_EN
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [c_SHAMT_W-1:0] c_LAST_ITER = c_SHAMT_W'(XLEN - 1);
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [XLEN-1:0]      r_result;
    logic [XLEN-1:0]      w_alu_result;
    logic [XLEN-1:0]      w_accept_result;
    logic [c_SHAMT_W-1:0] w_shamt;
    logic                 w_accept;
    logic                 w_start_calc;

    assign w_shamt  = i_operand2[c_SHAMT_W-1:0];
    assign w_accept = (r_state == c_ST_IDLE) && i_valid;

    always_comb begin
        w_alu_result = '0;
        case (i_operation)
            c_OP_ADD:  w_alu_result = i_operand1 + i_operand2;
            c_OP_SUB:  w_alu_result = i_operand1 - i_operand2;
            c_OP_AND:  w_alu_result = i_operand1 & i_operand2;
            c_OP_OR:   w_alu_result = i_operand1 | i_operand2;
            c_OP_XOR:  w_alu_result = i_operand1 ^ i_operand2;
            c_OP_SLL:  w_alu_result = i_operand1 << w_shamt;
            c_OP_SRL:  w_alu_result = i_operand1 >> w_shamt;
            c_OP_SRA:  w_alu_result = $unsigned($signed(i_operand1) >>> w_shamt);
            c_OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(i_operand1) < $signed(i_operand2)};
            c_OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, i_operand1 < i_operand2};
            default:   w_alu_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Codes 16..19 multiply, 20..23 divide; bit 2 splits mul from div.
    logic                 w_is_md, w_is_div;
    logic                 w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]      w_a_mag, w_b_mag;
    logic                 w_div_zero, w_div_ovf;
    logic [XLEN-1:0]      w_special_result;
    logic [2:0]           r_op;
    logic                 r_neg_lo, r_neg_rem;
    logic [XLEN-1:0]      r_hi, r_lo, r_divisor;
    logic [c_SHAMT_W-1:0] r_count;
    logic [XLEN:0]        w_mul_sum, w_rem_sh, w_rem_diff;
    logic [XLEN-1:0]      w_hi_nxt, w_lo_nxt;
    logic [2*XLEN-1:0]    w_product, w_product_s;
    logic [XLEN-1:0]      w_quot, w_rem, w_final;

    assign w_is_md    = (i_operation[4:3] == 2'b10);
    assign w_is_div   = w_is_md && i_operation[2];
    assign w_a_signed = w_is_div ? ~i_operation[0] : (i_operation[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? ~i_operation[0] : ~i_operation[1];
    assign w_a_neg    = w_a_signed && i_operand1[XLEN-1];
    assign w_b_neg    = w_b_signed && i_operand2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -i_operand1 : i_operand1;
    assign w_b_mag    = w_b_neg ? -i_operand2 : i_operand2;

    assign w_div_zero = w_is_div && (i_operand2 == '0);
    assign w_div_ovf  = w_is_div && !i_operation[0] &&
                        (i_operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_operand2 == '1);

    always_comb begin
        w_special_result = '0;
        if (w_div_zero)
            w_special_result = i_operation[1] ? i_operand1 : '1;
        else if (w_div_ovf)
            w_special_result = i_operation[1] ? '0 : i_operand1;
    end

    assign w_start_calc    = w_is_md && !w_div_zero && !w_div_ovf;
    assign w_accept_result = (w_div_zero || w_div_ovf) ? w_special_result : w_alu_result;

    // Multiply keeps {hi, lo} as a right-shifting product; divide keeps hi as
    // the partial remainder and shifts quotient bits into lo.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_divisor} : '0);
    assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_divisor};

    always_comb begin
        w_hi_nxt = w_mul_sum[XLEN:1];
        w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            if (!w_rem_diff[XLEN]) begin
                w_hi_nxt = w_rem_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rem_sh[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up is taken from the last iteration's next values so the
    // result lands in the same edge as the final iteration.
    assign w_product   = {w_hi_nxt, w_lo_nxt};
    assign w_product_s = r_neg_lo ? -w_product : w_product;
    assign w_quot      = r_neg_lo ? -w_lo_nxt : w_lo_nxt;
    assign w_rem       = r_neg_rem ? -w_hi_nxt : w_hi_nxt;

    always_comb begin
        w_final = w_product_s[2*XLEN-1:XLEN];
        if (r_op[2])
            w_final = r_op[1] ? w_rem : w_quot;
        else if (r_op[1:0] == 2'b00)
            w_final = w_product_s[XLEN-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_op      <= i_operation[2:0];
            r_neg_lo  <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_divisor <= w_b_mag;
            r_count   <= '0;
        end else if (r_state == c_ST_CALC) begin
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_count <= (r_count == c_LAST_ITER) ? '0 : r_count + 1'b1;
        end
    end
`else
    assign w_start_calc    = 1'b0;
    assign w_accept_result = w_alu_result;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (i_valid) w_state_nxt = w_start_calc ? 2'd1 : c_ST_DONE;
`ifdef ALU_MULDIV_EN
            c_ST_CALC: if (r_count == c_LAST_ITER) w_state_nxt = c_ST_DONE;
`endif
            c_ST_DONE: if (i_ready) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= c_ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_result <= '0;
        else if (w_accept)
            r_result <= w_accept_result;
`ifdef ALU_MULDIV_EN
        else if ((r_state == c_ST_CALC) && (r_count == c_LAST_ITER))
            r_result <= w_final;
`endif
    end

    assign o_ready  = (r_state == c_ST_IDLE);
    assign o_valid  = (r_state == c_ST_DONE);
    assign o_result = r_result;
    assign o_zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_iterative_alu                                                 |
// | Brief   : Directed vector bench for iterative_alu (both ALU_MULDIV_EN      |
// |           builds).                                                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_iterative_alu;

`ifdef ALU_MULDIV_EN
    localparam bit c_MD = 1'b1;
`else
    localparam bit c_MD = 1'b0;
`endif
    localparam int c_MLAT = c_MD ? 33 : 1;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic        r_clk = 1'b0;
    logic        r_rst_n = 1'b0;
    logic        r_valid = 1'b0;
    logic [4:0]  r_op = '0;
    logic [31:0] r_a = '0;
    logic [31:0] r_b = '0;
    logic        r_ready = 1'b0;
    logic        w_ready, w_valid, w_zero;
    logic [31:0] w_result;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] res;
    int          lat;
    vec_t        vecs[26];

    iterative_alu #(.XLEN(32)) dut (
        .i_clk       (r_clk),
        .i_rst_n     (r_rst_n),
        .i_valid     (r_valid),
        .o_ready     (w_ready),
        .i_operation (r_op),
        .i_operand1  (r_a),
        .i_operand2  (r_b),
        .o_valid     (w_valid),
        .i_ready     (r_ready),
        .o_result    (w_result),
        .o_zero      (w_zero)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns result and accept-to-valid latency.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int l);
        r_op = op; r_a = a; r_b = b; r_valid = 1'b1;
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        l = 1;
        while (w_valid !== 1'b1 && l < 100) begin
            @(posedge r_clk);
            #1 l++;
        end
        r = w_result;
    endtask

    task automatic release_result(input string name);
        r_ready = 1'b1;
        @(posedge r_clk);
        #1 r_ready = 1'b0;
        check({name, " valid drop"}, {31'd0, w_valid}, 32'd0);
        check({name, " ready rise"}, {31'd0, w_ready}, 32'd1);
    endtask

    function automatic logic [31:0] md(input logic [31:0] v);
        return c_MD ? v : 32'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "ADD wrap"};
        vecs[1]  = '{5'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, "SUB"};
        vecs[2]  = '{5'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1, "AND"};
        vecs[3]  = '{5'd3,  32'h1200_0034, 32'h0034_1200, 32'h1234_1234, 1, "OR"};
        vecs[4]  = '{5'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, "XOR"};
        vecs[5]  = '{5'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, "SLL"};
        vecs[6]  = '{5'd6,  32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1, "SRL"};
        vecs[7]  = '{5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, "SRA"};
        vecs[8]  = '{5'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, "SLT"};
        vecs[9]  = '{5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "SLTU"};
        vecs[10] = '{5'd10, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, "UNK10"};
        vecs[11] = '{5'd31, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, "UNK31"};
        vecs[12] = '{5'd17, 32'h8000_0000, 32'h8000_0000, md(32'h4000_0000), c_MLAT, "MULH"};
        vecs[13] = '{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'hFFFF_FFFF), c_MLAT, "MULHSU"};
        vecs[14] = '{5'd16, 32'h0000_0007, 32'hFFFF_FFFD, md(32'hFFFF_FFEB), c_MLAT, "MUL"};
        vecs[15] = '{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'hFFFF_FFFE), c_MLAT, "MULHU"};
        vecs[16] = '{5'd16, 32'h0000_0003, 32'h0000_0004, md(32'h0000_000C), c_MLAT, "MUL 3x4"};
        vecs[17] = '{5'd20, 32'hFFFF_FFF9, 32'h0000_0002, md(32'hFFFF_FFFD), c_MLAT, "DIV"};
        vecs[18] = '{5'd22, 32'hFFFF_FFF9, 32'h0000_0002, md(32'hFFFF_FFFF), c_MLAT, "REM"};
        vecs[19] = '{5'd21, 32'd100,       32'd7,         md(32'd14),        c_MLAT, "DIVU"};
        vecs[20] = '{5'd23, 32'd100,       32'd7,         md(32'd2),         c_MLAT, "REMU"};
        vecs[21] = '{5'd20, 32'd7,         32'hFFFF_FFFE, md(32'hFFFF_FFFD), c_MLAT, "DIV neg div"};
        vecs[22] = '{5'd21, 32'd5,         32'd0,         md(32'hFFFF_FFFF), 1, "DIVU by 0"};
        vecs[23] = '{5'd22, 32'd5,         32'd0,         md(32'd5),         1, "REM by 0"};
        vecs[24] = '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h8000_0000), 1, "DIV ovf"};
        vecs[25] = '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,     1, "REM ovf"};

        // Reset state
        #1;
        check("reset ready",  {31'd0, w_ready}, 32'd1);
        check("reset valid",  {31'd0, w_valid}, 32'd0);
        check("reset result", w_result, 32'd0);
        check("reset zero",   {31'd0, w_zero}, 32'd1);
        repeat (2) @(posedge r_clk);
        #1 r_rst_n = 1'b1;
        @(posedge r_clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            check({vecs[i].name, " ready"}, {31'd0, w_ready}, 32'd1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, " result"}, res, vecs[i].exp);
            check({vecs[i].name, " latency"}, lat, vecs[i].lat);
            check({vecs[i].name, " zero"}, {31'd0, w_zero}, {31'd0, vecs[i].exp == 32'd0});
            release_result(vecs[i].name);
        end

        // Backpressure: result held, new request ignored while in DONE
        run_op(5'd0, 32'h10, 32'h20, res, lat);
        check("bp first result", res, 32'h30);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                r_op = 5'd0; r_a = 32'd1; r_b = 32'd1; r_valid = 1'b1;
            end else begin
                r_valid = 1'b0;
            end
            @(posedge r_clk);
            #1;
            check("bp held result", w_result, 32'h30);
            check("bp ready low",   {31'd0, w_ready}, 32'd0);
            check("bp valid high",  {31'd0, w_valid}, 32'd1);
        end
        r_valid = 1'b0;
        release_result("bp");
        @(posedge r_clk);
        #1;
        check("bp no capture", {31'd0, w_valid}, 32'd0);
        check("bp result kept", w_result, 32'h30);

        // Reset mid-operation (CALC of DIVU when mul/div is built, else DONE)
        r_op = c_MD ? 5'd21 : 5'd0; r_a = c_MD ? 32'd100 : 32'h1234; r_b = c_MD ? 32'd7 : 32'd0;
        r_valid = 1'b1;
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        repeat (9) @(posedge r_clk);
        #1 r_rst_n = 1'b0;
        #1;
        check("abort ready",  {31'd0, w_ready}, 32'd1);
        check("abort valid",  {31'd0, w_valid}, 32'd0);
        check("abort result", w_result, 32'd0);
        check("abort zero",   {31'd0, w_zero}, 32'd1);
        @(posedge r_clk);
        #1 r_rst_n = 1'b1;
        @(posedge r_clk);
        #1;
        run_op(5'd0, 32'd2, 32'd3, res, lat);
        check("post-reset ADD", res, 32'd5);
        check("post-reset lat", lat, 1);
        release_result("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
